// File: rtl/uart2sample_mc_if.sv
// Byte-in / sample-out bundle for uart2sample_mc.
// master drives bytes and in_ready; slave is the assembler.
interface uart2sample_mc_if #(
   parameter int BPS = 24,
   parameter int CW  = 1
);
   logic           in_uart_ready;
   logic [7:0]     in_uart_frame;
   logic           in_ready;
   logic [BPS-1:0] out_frame;
   logic [CW-1:0]  out_channel;
   logic           out_ready;
   logic           out_overflow;
   logic           out_resync;

   modport master (
      output in_uart_ready,
      output in_uart_frame,
      output in_ready,
      input  out_frame,
      input  out_channel,
      input  out_ready,
      input  out_overflow,
      input  out_resync
   );

   modport slave (
      input  in_uart_ready,
      input  in_uart_frame,
      input  in_ready,
      output out_frame,
      output out_channel,
      output out_ready,
      output out_overflow,
      output out_resync
   );
endinterface

// File: rtl/uart2sample_mc.sv
// Packs UART bytes into BPS-bit channel-tagged samples with
// inter-byte timeout, one-deep holding register and sticky overflow.
module uart2sample_mc #(
   parameter int BPS          = 24,
   parameter int CHANNELS     = 2,
   parameter int LSB_FIRST    = 0,
   parameter int TIMEOUT_CLKS = 12800
) (
   input logic             in_clk,
   input logic             in_reset,
   uart2sample_mc_if.slave bus
);
   localparam int BYTES = (BPS + 7) / 8;
   localparam int W     = 8 * BYTES;
   localparam int CW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int BCW   = $clog2(BYTES + 1);
   localparam int TW    = $clog2(TIMEOUT_CLKS + 1);

   typedef enum logic {IDLE, ASSEMBLE} state_e;

   state_e         state_q, state_d;
   logic [BCW-1:0] bcnt_q, bcnt_d;
   logic [CW-1:0]  ch_q, ch_d;
   logic [CW-1:0]  och_q, och_d;
   logic [TW-1:0]  tmo_q, tmo_d;
   logic [W-1:0]   sh_q, sh_d;
   logic [BPS-1:0] frm_q, frm_d;
   logic           vld_q, vld_d;
   logic           ovf_q, ovf_d;
   logic           rsy_q, rsy_d;
   logic [W-1:0]   base, merged;
   logic           xfer, last, active;

   always_comb begin
      state_d = state_q;
      bcnt_d  = bcnt_q;
      ch_d    = ch_q;
      och_d   = och_q;
      tmo_d   = tmo_q;
      sh_d    = sh_q;
      frm_d   = frm_q;
      vld_d   = vld_q;
      ovf_d   = ovf_q;
      rsy_d   = 1'b0;

      xfer   = vld_q & bus.in_ready;
      last   = (bcnt_q == BCW'(BYTES - 1));
      active = (state_q != IDLE) || (ch_q != '0);
      base   = (state_q == IDLE) ? '0 : sh_q;
      if (LSB_FIRST != 0)
         merged = base | (W'(bus.in_uart_frame) << (8 * bcnt_q));
      else
         merged = (base << 8) | W'(bus.in_uart_frame);

      if (xfer)
         vld_d = 1'b0;

      // a strobe always beats a coincident timeout expiry
      if (bus.in_uart_ready) begin
         tmo_d = '0;
         sh_d  = merged;
         if (last) begin
            bcnt_d  = '0;
            state_d = IDLE;
            ch_d    = (ch_q == CW'(CHANNELS - 1)) ? '0 : ch_q + CW'(1);
            if (!vld_q || xfer) begin
               frm_d = merged[BPS-1:0];
               och_d = ch_q;
               vld_d = 1'b1;
            end else begin
               ovf_d = 1'b1;
            end
         end else begin
            bcnt_d  = bcnt_q + BCW'(1);
            state_d = ASSEMBLE;
         end
      end else if (active) begin
         if (tmo_q == TW'(TIMEOUT_CLKS - 1)) begin
            bcnt_d  = '0;
            ch_d    = '0;
            tmo_d   = '0;
            sh_d    = '0;
            state_d = IDLE;
            rsy_d   = 1'b1;
         end else begin
            tmo_d = tmo_q + TW'(1);
         end
      end
   end

   always_ff @(posedge in_clk) begin
      if (in_reset) begin
         state_q <= IDLE;
         bcnt_q  <= '0;
         ch_q    <= '0;
         och_q   <= '0;
         tmo_q   <= '0;
         sh_q    <= '0;
         frm_q   <= '0;
         vld_q   <= 1'b0;
         ovf_q   <= 1'b0;
         rsy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         bcnt_q  <= bcnt_d;
         ch_q    <= ch_d;
         och_q   <= och_d;
         tmo_q   <= tmo_d;
         sh_q    <= sh_d;
         frm_q   <= frm_d;
         vld_q   <= vld_d;
         ovf_q   <= ovf_d;
         rsy_q   <= rsy_d;
      end
   end

   assign bus.out_frame    = frm_q;
   assign bus.out_channel  = och_q;
   assign bus.out_ready    = vld_q;
   assign bus.out_overflow = ovf_q;
   assign bus.out_resync   = rsy_q;
endmodule

// File: tb/tb_uart2sample_mc.sv
// Three assembler variants fed one byte stream, each checked
// every cycle against a byte-queue reference model.
module tb_uart2sample_mc;
   localparam int NB  = 3;
   localparam int NCH = 2;
   localparam int TO  = 100;

   logic       clk = 1'b0;
   logic       rst;
   logic       stb;
   logic [7:0] byt;
   logic       rdy;

   always #5 clk = ~clk;

   uart2sample_mc_if #(.BPS(24), .CW(1)) u0 ();
   uart2sample_mc_if #(.BPS(24), .CW(1)) u1 ();
   uart2sample_mc_if #(.BPS(20), .CW(1)) u2 ();

   assign u0.in_uart_ready = stb;
   assign u0.in_uart_frame = byt;
   assign u0.in_ready      = rdy;
   assign u1.in_uart_ready = stb;
   assign u1.in_uart_frame = byt;
   assign u1.in_ready      = rdy;
   assign u2.in_uart_ready = stb;
   assign u2.in_uart_frame = byt;
   assign u2.in_ready      = rdy;

   uart2sample_mc #(.BPS(24), .CHANNELS(2), .LSB_FIRST(0),
      .TIMEOUT_CLKS(TO)) d0 (.in_clk(clk), .in_reset(rst), .bus(u0));
   uart2sample_mc #(.BPS(24), .CHANNELS(2), .LSB_FIRST(1),
      .TIMEOUT_CLKS(TO)) d1 (.in_clk(clk), .in_reset(rst), .bus(u1));
   uart2sample_mc #(.BPS(20), .CHANNELS(2), .LSB_FIRST(0),
      .TIMEOUT_CLKS(TO)) d2 (.in_clk(clk), .in_reset(rst), .bus(u2));

   logic [63:0] o_frm [3];
   logic [63:0] o_ch  [3];
   logic        o_rdy [3];
   logic        o_ovf [3];
   logic        o_rs  [3];

   assign o_frm[0] = 64'(u0.out_frame);
   assign o_frm[1] = 64'(u1.out_frame);
   assign o_frm[2] = 64'(u2.out_frame);
   assign o_ch[0]  = 64'(u0.out_channel);
   assign o_ch[1]  = 64'(u1.out_channel);
   assign o_ch[2]  = 64'(u2.out_channel);
   assign o_rdy[0] = u0.out_ready;
   assign o_rdy[1] = u1.out_ready;
   assign o_rdy[2] = u2.out_ready;
   assign o_ovf[0] = u0.out_overflow;
   assign o_ovf[1] = u1.out_overflow;
   assign o_ovf[2] = u2.out_overflow;
   assign o_rs[0]  = u0.out_resync;
   assign o_rs[1]  = u1.out_resync;
   assign o_rs[2]  = u2.out_resync;

   int     m_bps [3] = '{24, 24, 20};
   int     m_lsb [3] = '{0, 1, 0};
   int     cnt   [3];
   int     ch    [3];
   int     idle  [3];
   int     pend  [3][NB];
   bit     hv    [3];
   bit     ovf   [3];
   bit     rs    [3];
   longint hf    [3];
   int     hc    [3];

   int n_chk  = 0;
   int n_fail = 0;
   int rs_cnt = 0;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic void m_clear(input int i);
      cnt[i]  = 0;
      ch[i]   = 0;
      idle[i] = 0;
      hv[i]   = 0;
      ovf[i]  = 0;
      rs[i]   = 0;
      hf[i]   = 0;
      hc[i]   = 0;
   endfunction

   function automatic void m_step();
      for (int i = 0; i < 3; i++) begin
         bit     xfer;
         bit     loaded;
         longint v;
         xfer   = hv[i] && rdy;
         loaded = 0;
         rs[i]  = 0;
         if (rst) begin
            m_clear(i);
            continue;
         end
         if (stb) begin
            pend[i][cnt[i]] = int'(byt);
            idle[i] = 0;
            if (cnt[i] == NB - 1) begin
               v = 0;
               for (int k = 0; k < NB; k++)
                  if (m_lsb[i] != 0)
                     v = v + (longint'(pend[i][k]) << (8 * k));
                  else
                     v = v * 256 + longint'(pend[i][k]);
               v = v % (64'sd1 << m_bps[i]);
               if (!hv[i] || xfer) begin
                  hf[i]  = v;
                  hc[i]  = ch[i];
                  hv[i]  = 1;
                  loaded = 1;
               end else begin
                  ovf[i] = 1;
               end
               ch[i]  = (ch[i] + 1) % NCH;
               cnt[i] = 0;
            end else begin
               cnt[i]++;
            end
         end else if (cnt[i] != 0 || ch[i] != 0) begin
            idle[i]++;
            if (idle[i] == TO) begin
               cnt[i]  = 0;
               ch[i]   = 0;
               idle[i] = 0;
               rs[i]   = 1;
            end
         end
         if (xfer && !loaded)
            hv[i] = 0;
      end
   endfunction

   task automatic compare_all();
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("ready%0d", i), 64'(o_rdy[i]), 64'(hv[i]));
         if (hv[i]) begin
            chk($sformatf("frame%0d", i), o_frm[i], 64'(hf[i]));
            chk($sformatf("chan%0d", i), o_ch[i], 64'(hc[i]));
         end
         chk($sformatf("ovf%0d", i), 64'(o_ovf[i]), 64'(ovf[i]));
         chk($sformatf("resync%0d", i), 64'(o_rs[i]), 64'(rs[i]));
      end
      if (o_rs[0]) rs_cnt++;
   endtask

   task automatic cyc(input bit s, input logic [7:0] b, input bit r);
      stb = s;
      byt = b;
      rdy = r;
      @(posedge clk);
      m_step();
      @(negedge clk);
      compare_all();
   endtask

   task automatic send(input logic [7:0] b, input bit r);
      cyc(1'b1, b, r);
   endtask

   task automatic wait_idle(input int n, input bit r);
      for (int k = 0; k < n; k++)
         cyc(1'b0, 8'h00, r);
   endtask

   task automatic do_reset(input bit r);
      rst = 1'b1;
      cyc(1'b0, 8'h00, r);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      stb = 1'b0;
      byt = 8'h00;
      rdy = 1'b1;
      for (int i = 0; i < 3; i++) m_clear(i);
      do_reset(1'b1);
      chk("rst_frame", o_frm[0], 64'h0);
      chk("rst_chan", o_ch[0], 64'h0);
      chk("rst_ready", 64'(o_rdy[0]), 64'h0);
      chk("rst_ovf", 64'(o_ovf[0]), 64'h0);
      chk("rst_resync", 64'(o_rs[0]), 64'h0);

      // basic MSB-first assembly and channel rotation
      send(8'h12, 1'b1);
      send(8'h34, 1'b1);
      chk("lat_before", 64'(o_rdy[0]), 64'h0);
      send(8'h56, 1'b1);
      chk("lat_after", 64'(o_rdy[0]), 64'h1);
      chk("s1_frame", o_frm[0], 64'h123456);
      chk("s1_chan", o_ch[0], 64'h0);
      send(8'hAB, 1'b1);
      send(8'hCD, 1'b1);
      send(8'hEF, 1'b1);
      chk("s2_frame", o_frm[0], 64'hABCDEF);
      chk("s2_chan", o_ch[0], 64'h1);
      send(8'h56, 1'b1);
      send(8'h34, 1'b1);
      send(8'h12, 1'b1);
      chk("s3_lsb_frame", o_frm[1], 64'h123456);
      chk("s3_chan", o_ch[0], 64'h0);
      send(8'hF1, 1'b1);
      send(8'h23, 1'b1);
      send(8'h45, 1'b1);
      chk("s4_bps20", o_frm[2], 64'h12345);

      // timeout discards a partial sample
      rs_cnt = 0;
      send(8'h11, 1'b1);
      send(8'h22, 1'b1);
      wait_idle(99, 1'b1);
      chk("to_early", 64'(rs_cnt), 64'h0);
      wait_idle(1, 1'b1);
      chk("to_pulse", 64'(o_rs[0]), 64'h1);
      wait_idle(1, 1'b1);
      chk("to_once", 64'(rs_cnt), 64'h1);
      chk("to_no_ready", 64'(o_rdy[0]), 64'h0);
      send(8'h01, 1'b1);
      send(8'h02, 1'b1);
      send(8'h03, 1'b1);
      chk("to_frame", o_frm[0], 64'h010203);
      chk("to_chan", o_ch[0], 64'h0);

      // strobe landing on the expiry cycle wins
      rs_cnt = 0;
      send(8'h11, 1'b1);
      send(8'h22, 1'b1);
      wait_idle(99, 1'b1);
      send(8'h33, 1'b1);
      chk("exp_frame", o_frm[0], 64'h112233);
      chk("exp_chan", o_ch[0], 64'h1);
      wait_idle(2, 1'b1);
      chk("exp_no_rs", 64'(rs_cnt), 64'h0);

      // backpressure: hold, drop, release
      send(8'hA1, 1'b0);
      send(8'hA2, 1'b0);
      send(8'hA3, 1'b0);
      wait_idle(50, 1'b0);
      chk("bp_hold", o_frm[0], 64'hA1A2A3);
      send(8'hB1, 1'b0);
      send(8'hB2, 1'b0);
      send(8'hB3, 1'b0);
      chk("bp_ovf", 64'(o_ovf[0]), 64'h1);
      chk("bp_still_a", o_frm[0], 64'hA1A2A3);
      chk("bp_a_chan", o_ch[0], 64'h0);
      wait_idle(1, 1'b1);
      chk("bp_released", 64'(o_rdy[0]), 64'h0);
      send(8'hC1, 1'b1);
      send(8'hC2, 1'b1);
      send(8'hC3, 1'b1);
      chk("bp_next_chan", o_ch[0], 64'h0);
      wait_idle(5, 1'b1);
      chk("bp_ovf_sticky", 64'(o_ovf[0]), 64'h1);
      do_reset(1'b1);
      chk("bp_ovf_clr", 64'(o_ovf[0]), 64'h0);

      // free and load in the same cycle
      send(8'hD1, 1'b0);
      send(8'hD2, 1'b0);
      send(8'hD3, 1'b0);
      send(8'hE1, 1'b0);
      send(8'hE2, 1'b0);
      chk("fl_pre_ready", 64'(o_rdy[0]), 64'h1);
      send(8'hE3, 1'b1);
      chk("fl_ready", 64'(o_rdy[0]), 64'h1);
      chk("fl_frame", o_frm[0], 64'hE1E2E3);
      chk("fl_chan", o_ch[0], 64'h1);
      chk("fl_no_ovf", 64'(o_ovf[0]), 64'h0);
      wait_idle(1, 1'b1);

      // reset mid-assembly and while holding
      send(8'h55, 1'b1);
      send(8'h66, 1'b1);
      do_reset(1'b1);
      send(8'h0A, 1'b1);
      send(8'h0B, 1'b1);
      send(8'h0C, 1'b1);
      chk("rm_frame", o_frm[0], 64'h0A0B0C);
      chk("rm_chan", o_ch[0], 64'h0);
      send(8'h01, 1'b0);
      send(8'h02, 1'b0);
      send(8'h03, 1'b0);
      send(8'h04, 1'b0);
      send(8'h05, 1'b0);
      send(8'h06, 1'b0);
      chk("rh_ovf_set", 64'(o_ovf[0]), 64'h1);
      do_reset(1'b0);
      chk("rh_ready", 64'(o_rdy[0]), 64'h0);
      chk("rh_ovf", 64'(o_ovf[0]), 64'h0);

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         bit r;
         r = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 999) < 2) begin
            do_reset(r);
         end else if ($urandom_range(0, 99) < 3) begin
            wait_idle($urandom_range(80, 130), r);
         end else if ($urandom_range(0, 9) < 4) begin
            send(8'($urandom), r);
         end else begin
            wait_idle(1, r);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
